// File: rtl/bus_master_if.sv
// bus_master_if: turns a CPU load/store request into an arbitrated, strobed bus transaction with timeout.
module bus_master_if #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;
  state_t state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0] rd_data_d, wr_data_d;
  logic [29:0] addr_d;
  logic rw_d, done_d, err_d, active, hit, expire, accept;
  assign active = state == ACCESS || state == WAIT;
  assign accept = state == IDLE && cpu_req;
  assign hit    = active && !bus_rdy_;
  assign expire = active && bus_rdy_ && cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    next_state = state == IDLE ? (cpu_req ? REQ : IDLE)
               : state == REQ  ? (bus_grnt_ ? REQ : ACCESS)
               : (hit || expire) ? IDLE : WAIT;
  end
  // ready beats an expiring counter, so a slave answering on the last cycle still completes cleanly
  always_comb begin
    done_d    = hit || expire;
    err_d     = expire;
    cnt_d     = state == REQ ? '0 : active ? cnt + 1'b1 : cnt;
    rd_data_d = bus_rw && hit ? bus_rd_data : bus_rw && expire ? 32'h0 : cpu_rd_data;
    rw_d      = accept ? cpu_rw : bus_rw;
    addr_d    = accept ? cpu_addr : bus_addr;
    wr_data_d = accept ? cpu_wr_data : bus_wr_data;
  end
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state       <= IDLE;
      cnt         <= '0;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      cpu_rd_data <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_d;
      bus_req_    <= next_state == IDLE;
      bus_as_     <= next_state != ACCESS;
      bus_rw      <= rw_d;
      bus_addr    <= addr_d;
      bus_wr_data <= wr_data_d;
      cpu_rd_data <= rd_data_d;
      cpu_busy    <= next_state != IDLE;
      cpu_done    <= done_d;
      cpu_err     <= err_d;
    end
  end
endmodule
